// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the DDR3 app-interface arbiter.
// Holds MIG command codes, FSM state type and the requester-ID width helper.
package ddr3_arb_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // Requester-ID width; never below one bit.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// Ports: clk/rst, push+push_id, pop, head (pop_id), full, empty.
module ddr3_tag_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_id,
   input  logic         pop,
   output logic [W-1:0] pop_id,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_id  = mem[rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= push_id;
            wp      <= wp + AW'(1);
         end
         if (do_pop) rp <= rp + AW'(1);
         // Simultaneous push and pop leaves the count unchanged.
         if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
         else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Round-robin sharing of the MIG app interface between N_REQ requesters.
// Ports: req_* command side, rsp_* read return, app_* MIG side, error flag.
module ddr3_app_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 512,
   parameter int TAG_DEPTH  = 16
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        init_calib_complete,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ-1:0]            req_wr,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic                        app_en,
   output logic [2:0]                  app_cmd,
   output logic [ADDR_WIDTH-1:0]       app_addr,
   input  logic                        app_rdy,
   output logic                        app_wdf_wren,
   output logic                        app_wdf_end,
   output logic [DATA_WIDTH-1:0]       app_wdf_data,
   input  logic                        app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0]       app_rd_data,
   input  logic                        app_rd_data_valid,
   output logic                        err_unexpected_rd
);

   localparam int IDW = id_width(N_REQ);

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   win_c;
   logic             found;
   logic [N_REQ-1:0] elig;
   logic             done;
   logic             tag_push;
   logic             tag_pop;
   logic             tag_full;
   logic             tag_empty;
   logic [IDW-1:0]   tag_head;
   logic [N_REQ-1:0] rsp_next;

   // A read may only be granted while a tag slot is free.
   assign elig = req_valid & (req_wr | {N_REQ{~tag_full}});

   always_comb begin
      int idx;
      found = 1'b0;
      win_c = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win_c = IDW'(idx);
         end
      end
   end

   // Writes need command and data accepted together.
   assign done = (state == ISSUE) && app_rdy &&
                 (!app_wdf_wren || app_wdf_rdy);

   assign tag_push    = done && (app_cmd == CMD_RD);
   assign tag_pop     = app_rd_data_valid && !tag_empty;
   assign app_wdf_end = app_wdf_wren;

   always_comb begin
      req_ready = '0;
      rsp_next  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = done && (win == IDW'(i));
         rsp_next[i]  = tag_pop && (tag_head == IDW'(i));
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= IDLE;
         ptr          <= '0;
         win          <= '0;
         app_en       <= 1'b0;
         app_cmd      <= '0;
         app_addr     <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (init_calib_complete && found) begin
                  state        <= ISSUE;
                  win          <= win_c;
                  app_en       <= 1'b1;
                  app_cmd      <= req_wr[win_c] ? CMD_WR : CMD_RD;
                  app_addr     <= req_addr[int'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
                  app_wdf_data <= req_wdata[int'(win_c)*DATA_WIDTH +: DATA_WIDTH];
                  app_wdf_wren <= req_wr[win_c];
               end
            end
            ISSUE: begin
               if (done) begin
                  state        <= IDLE;
                  app_en       <= 1'b0;
                  app_wdf_wren <= 1'b0;
                  ptr          <= (win == IDW'(N_REQ-1)) ? '0 : win + IDW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rsp_valid         <= '0;
         rsp_data          <= '0;
         err_unexpected_rd <= 1'b0;
      end else begin
         rsp_valid <= rsp_next;
         if (tag_pop) rsp_data <= app_rd_data;
         // A beat with no owner is dropped and flagged.
         if (app_rd_data_valid && tag_empty) err_unexpected_rd <= 1'b1;
      end
   end

   ddr3_tag_fifo #(
      .W     (IDW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .push    (tag_push),
      .push_id (win),
      .pop     (tag_pop),
      .pop_id  (tag_head),
      .full    (tag_full),
      .empty   (tag_empty)
   );

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter with two requesters.
// Stimulus queues expected commands/responses; a monitor compares them.
module tb_ddr3_app_arbiter;

   localparam int N  = 2;
   localparam int AW = 28;
   localparam int DW = 512;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            calib = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_wr = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            app_en;
   logic [2:0]      app_cmd;
   logic [AW-1:0]   app_addr;
   logic            app_rdy = 1'b0;
   logic            app_wdf_wren;
   logic            app_wdf_end;
   logic [DW-1:0]   app_wdf_data;
   logic            app_wdf_rdy = 1'b0;
   logic [DW-1:0]   app_rd_data = '0;
   logic            app_rd_data_valid = 1'b0;
   logic            err;

   typedef struct {
      logic [N-1:0]  rdy;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct {
      logic [N-1:0]  oh;
      logic [DW-1:0] data;
   } rsp_t;

   cmd_t cq[$];
   rsp_t rq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   ddr3_app_arbiter dut (
      .sys_clk             (clk),
      .sys_rst             (rst),
      .init_calib_complete (calib),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_wr              (req_wr),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .rsp_valid           (rsp_valid),
      .rsp_data            (rsp_data),
      .app_en              (app_en),
      .app_cmd             (app_cmd),
      .app_addr            (app_addr),
      .app_rdy             (app_rdy),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .err_unexpected_rd   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input logic [31:0] w);
      return {16{w}};
   endfunction

   task automatic expect_cmd(input int id, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_t c;
      c.rdy  = N'(1) << id;
      c.wr   = wr;
      c.addr = a;
      c.data = d;
      cq.push_back(c);
   endtask

   task automatic expect_rsp(input logic [N-1:0] oh, input logic [DW-1:0] d);
      rsp_t r;
      r.oh   = oh;
      r.data = d;
      rq.push_back(r);
   endtask

   task automatic drive(input int id, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[id]         = 1'b1;
      req_wr[id]            = wr;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*DW +: DW] = d;
   endtask

   // Requester drops valid at the accept cycle's falling edge.
   task automatic wait_ready(input int id);
      bit got = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            got = 1'b1;
            break;
         end
      end
      req_valid[id] = 1'b0;
      if (!got) chk("ready_timeout", 0, 1);
   endtask

   task automatic issue(input int id, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      expect_cmd(id, wr, a, d);
      drive(id, wr, a, d);
      wait_ready(id);
   endtask

   task automatic beat(input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b1;
      app_rd_data       = d;
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every accepted command and every read response is scored.
   always @(negedge clk) begin
      if (!rst) begin
         if (app_en && app_rdy && (!app_wdf_wren || app_wdf_rdy)) begin
            if (cq.size() == 0) begin
               chk("cmd_unexpected", 1, 0);
            end else begin
               cmd_t c;
               c = cq.pop_front();
               chk("cmd_ready", req_ready, c.rdy);
               chk("cmd_code", app_cmd, c.wr ? 3'b000 : 3'b001);
               chk("cmd_addr", app_addr, c.addr);
               chk("cmd_wren", app_wdf_wren, c.wr);
               chk("cmd_wend", app_wdf_end, c.wr);
               if (c.wr) chk("cmd_wdata", app_wdf_data, c.data);
            end
         end else if (req_ready != '0) begin
            chk("ready_spurious", req_ready, 0);
         end
         if (rsp_valid != '0) begin
            if (rq.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               rsp_t r;
               r = rq.pop_front();
               chk("rsp_onehot", rsp_valid, r.oh);
               chk("rsp_data", rsp_data, r.data);
            end
         end
      end
   end

   initial begin
      bit bad;
      int last;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_app_en", app_en, 0);
      chk("rst_wren", {app_wdf_wren, app_wdf_end}, 0);
      chk("rst_cmd_addr", {app_cmd, app_addr}, 0);
      chk("rst_wdata", app_wdf_data, 0);
      chk("rst_ready_rsp", {req_ready, rsp_valid, err}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Calibration gating
      expect_cmd(0, 1'b1, 28'h00000A0, pat(32'h1111_0001));
      drive(0, 1'b1, 28'h00000A0, pat(32'h1111_0001));
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (app_en) bad = 1'b1;
      end
      chk("calib_gate", bad, 0);
      @(posedge clk);
      #1;
      calib = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("calib_en", app_en, 1);
      chk("calib_cmd", app_cmd, 3'b000);
      @(posedge clk);
      #1;
      app_rdy     = 1'b1;
      app_wdf_rdy = 1'b1;
      wait_ready(0);

      // Write backpressure
      @(posedge clk);
      #1;
      app_wdf_rdy = 1'b0;
      expect_cmd(0, 1'b1, 28'h0000040, pat(32'hDA7A_0040));
      drive(0, 1'b1, 28'h0000040, pat(32'hDA7A_0040));
      @(posedge clk);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!app_en || !app_wdf_wren || req_ready != '0) bad = 1'b1;
         if (app_addr != 28'h40 || app_wdf_data != pat(32'hDA7A_0040))
            bad = 1'b1;
      end
      chk("bp_hold", bad, 0);
      @(posedge clk);
      #1;
      app_wdf_rdy = 1'b1;
      @(negedge clk);
      chk("bp_release", req_ready, 2'b01);
      req_valid[0] = 1'b0;

      // Round robin with continuous reads
      do_reset();
      for (int k = 0; k < 4; k++)
         expect_cmd(k % 2, 1'b0, (k % 2) ? 28'h20 : 28'h10, '0);
      drive(0, 1'b0, 28'h10, '0);
      drive(1, 1'b0, 28'h20, '0);
      last = 0;
      for (int k = 0; k < 4; k++) begin
         bad = 1'b1;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
               bad = 1'b0;
               break;
            end
         end
         if (k == 3) req_valid = '0;
         chk("rr_seen", bad, 0);
         if (k > 0) chk("rr_gap", cyc - last, 2);
         last = cyc;
         @(negedge clk);
         chk("rr_width", req_ready, 0);
      end

      // Read steering
      do_reset();
      issue(1, 1'b0, 28'h100, '0);
      issue(0, 1'b0, 28'h200, '0);
      issue(1, 1'b0, 28'h300, '0);
      expect_rsp(2'b10, pat(32'hD1D1_0001));
      expect_rsp(2'b01, pat(32'hD2D2_0002));
      expect_rsp(2'b10, pat(32'hD3D3_0003));
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b1;
      app_rd_data       = pat(32'hD1D1_0001);
      @(negedge clk);
      chk("rd_lat_pre", rsp_valid, 0);
      @(posedge clk);
      #1;
      app_rd_data = pat(32'hD2D2_0002);
      @(negedge clk);
      chk("rd_lat_post", rsp_valid, 2'b10);
      @(posedge clk);
      #1;
      app_rd_data = pat(32'hD3D3_0003);
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      chk("rd_rsp_drained", rq.size(), 0);

      // Tag FIFO full
      do_reset();
      for (int k = 0; k < 15; k++) issue(0, 1'b0, 28'(k), '0);
      issue(1, 1'b0, 28'h0F, '0);
      expect_cmd(1, 1'b1, 28'h600, pat(32'hBEEF_0600));
      drive(1, 1'b1, 28'h600, pat(32'hBEEF_0600));
      drive(0, 1'b0, 28'h500, '0);
      wait_ready(1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (app_en) bad = 1'b1;
      end
      chk("full_block", bad, 0);
      expect_cmd(0, 1'b0, 28'h500, '0);
      expect_rsp(2'b01, pat(32'hCAFE_0000));
      beat(pat(32'hCAFE_0000));
      wait_ready(0);

      // Unexpected read data and mid-issue reset
      do_reset();
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b1;
      app_rd_data       = pat(32'h0BAD_0BAD);
      @(negedge clk);
      chk("unexp_pre", err, 0);
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk("unexp_rsp", rsp_valid, 0);
      chk("unexp_err", err, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("unexp_sticky", err, 1);
      app_rdy = 1'b0;
      drive(0, 1'b0, 28'h77, pat(32'h7777_7777));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_issue_en", {app_en, app_cmd}, {1'b1, 3'b001});
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_en", {app_en, app_wdf_wren, app_wdf_end}, 0);
      chk("mid_rst_cmd", {app_cmd, app_addr}, 0);
      chk("mid_rst_wdata", app_wdf_data, 0);
      chk("mid_rst_err", {err, req_ready, rsp_valid}, 0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      app_rdy = 1'b1;
      repeat (3) @(posedge clk);

      chk("cmd_q_empty", cq.size(), 0);
      chk("rsp_q_empty", rq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
